restoring_divider: RTL
======================

# restoring_divider

Parametrised multi-cycle restoring divider producing one quotient bit per clock. It accepts a dividend/divisor pair over a valid/ready handshake, runs `WIDTH` shift-subtract-restore iterations, and returns quotient, remainder and a divide-by-zero flag over a second valid/ready handshake. It is the sequential successor to the team's single-step restoring-division ALU and replaces the external controller/datapath pairing with one self-contained block.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width; legal range 2 to 64.
- `clk`  in  1  clock, all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `src_valid`  in  1  operand pair is valid.
- `src_ready`  out  1  block can accept operands; high only in IDLE.
- `dividend`  in  WIDTH  dividend, sampled on the accept edge.
- `divisor`  in  WIDTH  divisor, sampled on the accept edge.
- `dest_valid`  out  1  result is valid; high only in DONE.
- `dest_ready`  in  1  consumer takes the result.
- `quotient`  out  WIDTH  quotient.
- `remainder`  out  WIDTH  remainder.
- `div_by_zero`  out  1  divisor was zero; valid with `dest_valid`.

## Operation
- FSM states are IDLE, BUSY and DONE.
- IDLE -> BUSY on `src_valid && src_ready`. That edge latches the operands, clears the partial remainder A (WIDTH+1 bits), loads Q with the dividend magnitude, and loads the iteration counter with `WIDTH`.
- Each BUSY cycle performs one iteration:
  - Shift {A,Q} left one bit.
  - Compute A - M.
  - If the result is negative, restore A and clear Q[0]. Otherwise keep the difference and set Q[0].
  - Decrement the counter.
- BUSY -> DONE on the edge that completes the iteration with counter == 1. The same edge registers `quotient`, `remainder` and `div_by_zero` after sign correction.
- DONE -> IDLE on `dest_valid && dest_ready`. Outputs hold stable while `dest_ready` is low.
- Divide by zero:
  - Iterations still run and latency is unchanged.
  - Output `quotient` = all ones, `remainder` = original dividend, `div_by_zero` = 1, in both arithmetic modes.
- Inputs other than `rst` are ignored while the FSM is in BUSY or DONE.
- `src_valid` may drop without being accepted; no state changes.

## Timing
- Reset values:
  - state = IDLE, `src_ready` = 1, `dest_valid` = 0.
  - `quotient`, `remainder` = 0, `div_by_zero` = 0.
  - Counter, A, Q and M = 0.
- `rst` asserted at any time, including mid-BUSY or DONE, aborts the operation immediately. The in-flight result is discarded and never presented.
- Latency: if the operands are accepted on edge k, `dest_valid` rises after edge k+WIDTH.
- Throughput: at most one operation per WIDTH+2 cycles when `dest_ready` is held high. There is no accept in the cycle the result is consumed.
- `src_ready` is 0 from the cycle after accept until the cycle after the result is consumed.

## Configuration
- Macro: `RESTORING_DIVIDER_SIGNED_EN`.
- Defined: operands are two's-complement signed.
  - Magnitudes are divided.
  - Quotient is negated when the operand signs differ; it truncates toward zero.
  - Remainder takes the sign of the dividend.
  - MIN / -1 returns quotient = MIN and remainder = 0, with no flag.
  - Divide-by-zero outputs are as stated in Operation.
- Undefined: operands are unsigned and no sign-correction logic is built.
- Latency and ports are identical in both builds.

## Test plan
All scenarios use WIDTH=16.
- Unsigned 100 / 7 -> `quotient` = 14, `remainder` = 2, `div_by_zero` = 0. `dest_valid` rises exactly 16 edges after the accept edge.
- Unsigned 0xFFFF / 0x0001 -> `quotient` = 0xFFFF, `remainder` = 0. 0x0005 / 0x0009 -> `quotient` = 0, `remainder` = 5.
- 0x1234 / 0 -> `quotient` = 0xFFFF, `remainder` = 0x1234, `div_by_zero` = 1. The next operation 10 / 3 gives `div_by_zero` = 0.
- Signed build:
  - -7 / 2 -> `quotient` = 0xFFFD, `remainder` = 0xFFFF.
  - 7 / -2 -> `quotient` = 0xFFFD, `remainder` = 0x0001.
  - 0x8000 / 0xFFFF -> `quotient` = 0x8000, `remainder` = 0.
- Backpressure: hold `dest_ready` = 0 for 5 cycles in DONE -> outputs and `dest_valid` stay constant and `src_ready` stays 0. Raising `dest_ready` -> IDLE next cycle with `src_ready` = 1.
- Assert `rst` on the 8th BUSY cycle of 1000 / 3 -> all outputs return to reset values asynchronously and `dest_valid` never asserts. A following 9 / 4 -> `quotient` = 2, `remainder` = 1.

Source files
------------

// File: rtl/restoring_divider_if.sv
// Operand and result handshake bundle for restoring_divider.
// Handshake: a transfer happens on a rising clk edge where valid && ready are both high;
// the producer holds valid and data stable until that edge, and ready never waits on valid.
interface restoring_divider_if #(
  parameter int WIDTH = 16
);
  logic             src_valid;
  logic             src_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             dest_valid;
  logic             dest_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output src_valid, dividend, divisor, dest_ready,
    input  src_ready, dest_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  src_valid, dividend, divisor, dest_ready,
    output src_ready, dest_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define RESTORING_DIVIDER_SIGNED_EN for two's-complement operands (default: unsigned).
module restoring_divider #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  restoring_divider_if.slave  bus,
  output logic [1:0]          fsm_state
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] dvd;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   a_diff;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;
  logic             unused_bits;

  assign fsm_state   = state;
  // A stays below M, so its top bit is always zero going into a shift.
  assign unused_bits = a[WIDTH] ^ a_next[WIDTH];

  always_comb begin
    a_shift = {a[WIDTH-1:0], q[WIDTH-1]};
    a_diff  = a_shift - {1'b0, m};
    a_next  = a_shift;
    q_next  = {q[WIDTH-2:0], 1'b0};
    if (!a_diff[WIDTH]) begin
      a_next = a_diff;
      q_next = {q[WIDTH-2:0], 1'b1};
    end
  end

`ifdef RESTORING_DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;

  always_comb begin
    dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    dsr_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    q_res   = neg_q ? -q_next : q_next;
    r_res   = neg_r ? -a_next[WIDTH-1:0] : a_next[WIDTH-1:0];
  end

  // Sign fixes are decided at accept time; MIN/-1 falls out naturally as MIN, remainder 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && bus.src_valid) begin
      neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      neg_r <= bus.dividend[WIDTH-1];
    end
  end
`else
  always_comb begin
    dvd_mag = bus.dividend;
    dsr_mag = bus.divisor;
    q_res   = q_next;
    r_res   = a_next[WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bus.src_ready   <= 1'b1;
      bus.dest_valid  <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      a               <= '0;
      q               <= '0;
      m               <= '0;
      dvd             <= '0;
      cnt             <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.src_valid) begin
            state         <= BUSY;
            bus.src_ready <= 1'b0;
            a             <= '0;
            q             <= dvd_mag;
            m             <= dsr_mag;
            dvd           <= bus.dividend;
            cnt           <= CW'(WIDTH);
          end
        end
        BUSY: begin
          a   <= a_next;
          q   <= q_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state          <= DONE;
            bus.dest_valid <= 1'b1;
            if (m == '0) begin
              bus.quotient    <= '1;
              bus.remainder   <= dvd;
              bus.div_by_zero <= 1'b1;
            end else begin
              bus.quotient    <= q_res;
              bus.remainder   <= r_res;
              bus.div_by_zero <= 1'b0;
            end
          end
        end
        DONE: begin
          if (bus.dest_ready) begin
            state          <= IDLE;
            bus.dest_valid <= 1'b0;
            bus.src_ready  <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          bus.src_ready  <= 1'b1;
          bus.dest_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
